// File: rtl/aexm_refill_arb.sv
// Shared backing-memory arbiter for aexm icache/dcache line refills and dcache writebacks.
// One fixed-length burst at a time, round-robin between the two caches on simultaneous requests.
module aexm_refill_arb #(
  parameter int BURST_LEN = 4,
  parameter int LW        = 2
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        ic_req_i,
  input  logic [31:0] ic_addr_i,
  output logic [31:0] ic_data_o,
  output logic        ic_valid_o,
  output logic        ic_done_o,
  input  logic        dc_req_i,
  input  logic        dc_we_i,
  input  logic [31:0] dc_addr_i,
  input  logic [31:0] dc_wdata_i,
  output logic        dc_wack_o,
  output logic [31:0] dc_data_o,
  output logic        dc_valid_o,
  output logic        dc_done_o,
  output logic        mem_cmd_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_cmd_ack_i,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_wready_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rvalid_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [31:0]   ADDR_MASK = ~((32'd1 << (LW + 2)) - 32'd1);
  localparam logic [LW-1:0] CNT_LAST  = LW'(BURST_LEN - 1);

  state_t        state_q, state_d;
  logic          grant_q, grant_d;            // 0 = icache, 1 = dcache
  logic          last_grant_q, last_grant_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic          ic_valid_q, ic_valid_d;
  logic [31:0]   ic_data_q, ic_data_d;
  logic          dc_valid_q, dc_valid_d;
  logic [31:0]   dc_data_q, dc_data_d;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= 32'd0;
      we_q         <= 1'b0;
      ic_valid_q   <= 1'b0;
      ic_data_q    <= 32'd0;
      dc_valid_q   <= 1'b0;
      dc_data_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      ic_valid_q   <= ic_valid_d;
      ic_data_q    <= ic_data_d;
      dc_valid_q   <= dc_valid_d;
      dc_data_q    <= dc_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    we_d         = we_q;
    ic_valid_d   = 1'b0;
    ic_data_d    = 32'd0;
    dc_valid_d   = 1'b0;
    dc_data_d    = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (ic_req_i || dc_req_i) begin
          if (ic_req_i && dc_req_i) begin
            grant_d = ~last_grant_q;
          end else begin
            grant_d = dc_req_i;
          end
          last_grant_d = grant_d;
          addr_d       = (grant_d ? dc_addr_i : ic_addr_i) & ADDR_MASK;
          we_d         = grant_d ? dc_we_i : 1'b0;
          cnt_d        = '0;
          state_d      = ST_CMD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (mem_cmd_ack_i) begin
          state_d = ST_XFER;
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_XFER: begin
        // cnt wraps to 0 on the final beat; harmless since we leave XFER
        if (we_q) begin
          if (mem_wready_i) begin
            cnt_d = cnt_q + LW'(1);
            if (cnt_q == CNT_LAST) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_XFER;
            end
          end else begin
            state_d = ST_XFER;
          end
        end else begin
          if (mem_rvalid_i) begin
            cnt_d = cnt_q + LW'(1);
            if (grant_q) begin
              dc_valid_d = 1'b1;
              dc_data_d  = mem_rdata_i;
            end else begin
              ic_valid_d = 1'b1;
              ic_data_d  = mem_rdata_i;
            end
            if (cnt_q == CNT_LAST) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_XFER;
            end
          end else begin
            state_d = ST_XFER;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    mem_cmd_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'd0;
    mem_wdata_o = 32'd0;
    dc_wack_o   = 1'b0;
    ic_done_o   = 1'b0;
    dc_done_o   = 1'b0;
    case (state_q)
      ST_CMD: begin
        mem_cmd_o  = 1'b1;
        mem_we_o   = we_q;
        mem_addr_o = addr_q;
      end
      ST_XFER: begin
        mem_we_o   = we_q;
        mem_addr_o = addr_q;
        if (we_q) begin
          mem_wdata_o = dc_wdata_i;
          dc_wack_o   = mem_wready_i;
        end else begin
          mem_wdata_o = 32'd0;
          dc_wack_o   = 1'b0;
        end
      end
      ST_DONE: begin
        ic_done_o = ~grant_q;
        dc_done_o = grant_q;
      end
      default: begin
        mem_cmd_o = 1'b0;
      end
    endcase
  end

  assign ic_valid_o = ic_valid_q;
  assign ic_data_o  = ic_data_q;
  assign dc_valid_o = dc_valid_q;
  assign dc_data_o  = dc_data_q;

endmodule

// File: tb/tb_aexm_refill_arb.sv
// Directed bench for aexm_refill_arb: cycle tables for a plain refill and a writeback,
// then hand sequences for arbitration, command stall, mid-burst reset and re-request.
module tb_aexm_refill_arb;

  logic        clk;
  logic        sys_rst_i;
  logic        ic_req_i;
  logic [31:0] ic_addr_i;
  logic [31:0] ic_data_o;
  logic        ic_valid_o;
  logic        ic_done_o;
  logic        dc_req_i;
  logic        dc_we_i;
  logic [31:0] dc_addr_i;
  logic [31:0] dc_wdata_i;
  logic        dc_wack_o;
  logic [31:0] dc_data_o;
  logic        dc_valid_o;
  logic        dc_done_o;
  logic        mem_cmd_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic        mem_cmd_ack_i;
  logic [31:0] mem_wdata_o;
  logic        mem_wready_i;
  logic [31:0] mem_rdata_i;
  logic        mem_rvalid_i;

  int n_checks = 0;
  int n_errors = 0;

  aexm_refill_arb #(.BURST_LEN(4), .LW(2)) dut (
    .sys_clk_i(clk), .sys_rst_i(sys_rst_i),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_data_o(ic_data_o),
    .ic_valid_o(ic_valid_o), .ic_done_o(ic_done_o),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i),
    .dc_wdata_i(dc_wdata_i), .dc_wack_o(dc_wack_o), .dc_data_o(dc_data_o),
    .dc_valid_o(dc_valid_o), .dc_done_o(dc_done_o),
    .mem_cmd_o(mem_cmd_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_cmd_ack_i(mem_cmd_ack_i), .mem_wdata_o(mem_wdata_o),
    .mem_wready_i(mem_wready_i), .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        dc_req;
    logic        dc_we;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic        ack;
    logic        wready;
    logic [31:0] rdata;
    logic        rvalid;
  } in_t;

  typedef struct packed {
    logic [31:0] ic_data;
    logic        ic_valid;
    logic        ic_done;
    logic        dc_wack;
    logic [31:0] dc_data;
    logic        dc_valid;
    logic        dc_done;
    logic        cmd;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  vec_t vecs[$];

  function automatic in_t rd_in(logic req, logic ack, logic rv, logic [31:0] rd);
    in_t r;
    r = '0;
    r.ic_req  = req;
    r.ic_addr = 32'h0000_1234;
    r.ack     = ack;
    r.rvalid  = rv;
    r.rdata   = rd;
    return r;
  endfunction

  function automatic exp_t ic_exp(logic cmd, logic [31:0] addr, logic v, logic [31:0] d, logic done);
    exp_t r;
    r = '0;
    r.cmd      = cmd;
    r.addr     = addr;
    r.ic_valid = v;
    r.ic_data  = d;
    r.ic_done  = done;
    return r;
  endfunction

  function automatic in_t wr_in(logic req, logic ack, logic wr, logic [31:0] wd, logic rv, logic [31:0] rd);
    in_t r;
    r = '0;
    r.dc_req   = req;
    r.dc_we    = 1'b1;
    r.dc_addr  = 32'h8000_004C;
    r.ack      = ack;
    r.wready   = wr;
    r.dc_wdata = wd;
    r.rvalid   = rv;
    r.rdata    = rd;
    return r;
  endfunction

  function automatic exp_t dc_exp(logic cmd, logic we, logic [31:0] addr, logic wack, logic [31:0] wd, logic done);
    exp_t r;
    r = '0;
    r.cmd     = cmd;
    r.we      = we;
    r.addr    = addr;
    r.dc_wack = wack;
    r.wdata   = wd;
    r.dc_done = done;
    return r;
  endfunction

  task automatic add(in_t i, exp_t e);
    vec_t v;
    v.i = i;
    v.e = e;
    vecs.push_back(v);
  endtask

  task automatic apply(in_t i);
    ic_req_i      = i.ic_req;
    ic_addr_i     = i.ic_addr;
    dc_req_i      = i.dc_req;
    dc_we_i       = i.dc_we;
    dc_addr_i     = i.dc_addr;
    dc_wdata_i    = i.dc_wdata;
    mem_cmd_ack_i = i.ack;
    mem_wready_i  = i.wready;
    mem_rdata_i   = i.rdata;
    mem_rvalid_i  = i.rvalid;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cmp_all(string nm, exp_t e);
    exp_t a;
    a.ic_data  = ic_data_o;
    a.ic_valid = ic_valid_o;
    a.ic_done  = ic_done_o;
    a.dc_wack  = dc_wack_o;
    a.dc_data  = dc_data_o;
    a.dc_valid = dc_valid_o;
    a.dc_done  = dc_done_o;
    a.cmd      = mem_cmd_o;
    a.we       = mem_we_o;
    a.addr     = mem_addr_o;
    a.wdata    = mem_wdata_o;
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL %s: outputs got %h expected %h", nm, a, e);
    end
  endtask

  // Entered at the start of a CMD cycle; acks at once, feeds four read beats, checks DONE.
  task automatic do_read_burst(string nm, bit exp_dc, logic [31:0] exp_addr, logic [31:0] base, bit keep);
    mem_cmd_ack_i = 1'b1;
    @(negedge clk);
    chk({nm, " cmd"}, {31'd0, mem_cmd_o}, 32'd1);
    chk({nm, " addr"}, mem_addr_o, exp_addr);
    chk({nm, " we"}, {31'd0, mem_we_o}, 32'd0);
    step();
    mem_cmd_ack_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = base + 32'(k);
      step();
    end
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'd0;
    @(negedge clk);
    chk({nm, " done"}, {30'd0, ic_done_o, dc_done_o}, exp_dc ? 32'd1 : 32'd2);
    chk({nm, " valid"}, {30'd0, ic_valid_o, dc_valid_o}, exp_dc ? 32'd1 : 32'd2);
    chk({nm, " last data"}, exp_dc ? dc_data_o : ic_data_o, base + 32'd3);
    chk({nm, " other data"}, exp_dc ? ic_data_o : dc_data_o, 32'd0);
    step();
    if (!keep) begin
      if (exp_dc) dc_req_i = 1'b0;
      else        ic_req_i = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    apply('0);
    sys_rst_i = 1'b1;

    // icache refill with a 2-cycle ack delay and one gap between beats
    add(rd_in(1'b1, 1'b0, 1'b0, 32'h0),  ic_exp(1'b0, 32'h0,         1'b0, 32'h0,  1'b0));
    add(rd_in(1'b1, 1'b0, 1'b0, 32'h0),  ic_exp(1'b1, 32'h0000_1230, 1'b0, 32'h0,  1'b0));
    add(rd_in(1'b1, 1'b0, 1'b0, 32'h0),  ic_exp(1'b1, 32'h0000_1230, 1'b0, 32'h0,  1'b0));
    add(rd_in(1'b1, 1'b1, 1'b0, 32'h0),  ic_exp(1'b1, 32'h0000_1230, 1'b0, 32'h0,  1'b0));
    add(rd_in(1'b1, 1'b0, 1'b1, 32'hA0), ic_exp(1'b0, 32'h0000_1230, 1'b0, 32'h0,  1'b0));
    add(rd_in(1'b1, 1'b0, 1'b1, 32'hA1), ic_exp(1'b0, 32'h0000_1230, 1'b1, 32'hA0, 1'b0));
    add(rd_in(1'b1, 1'b0, 1'b0, 32'h0),  ic_exp(1'b0, 32'h0000_1230, 1'b1, 32'hA1, 1'b0));
    add(rd_in(1'b1, 1'b0, 1'b1, 32'hA2), ic_exp(1'b0, 32'h0000_1230, 1'b0, 32'h0,  1'b0));
    add(rd_in(1'b1, 1'b0, 1'b1, 32'hA3), ic_exp(1'b0, 32'h0000_1230, 1'b1, 32'hA2, 1'b0));
    add(rd_in(1'b1, 1'b0, 1'b0, 32'h0),  ic_exp(1'b0, 32'h0,         1'b1, 32'hA3, 1'b1));
    add(rd_in(1'b0, 1'b0, 1'b0, 32'h0),  ic_exp(1'b0, 32'h0,         1'b0, 32'h0,  1'b0));
    add(rd_in(1'b0, 1'b0, 1'b1, 32'hEE), ic_exp(1'b0, 32'h0,         1'b0, 32'h0,  1'b0));
    add(rd_in(1'b0, 1'b0, 1'b0, 32'h0),  ic_exp(1'b0, 32'h0,         1'b0, 32'h0,  1'b0));
    // dcache writeback, wready on alternate cycles, stray rvalid mid-burst
    add(wr_in(1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0),   dc_exp(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,  1'b0));
    add(wr_in(1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0),   dc_exp(1'b1, 1'b1, 32'h8000_0040, 1'b0, 32'h0,  1'b0));
    add(wr_in(1'b1, 1'b0, 1'b1, 32'hD0, 1'b0, 32'h0),   dc_exp(1'b0, 1'b1, 32'h8000_0040, 1'b1, 32'hD0, 1'b0));
    add(wr_in(1'b1, 1'b0, 1'b0, 32'hD1, 1'b1, 32'hBAD), dc_exp(1'b0, 1'b1, 32'h8000_0040, 1'b0, 32'hD1, 1'b0));
    add(wr_in(1'b1, 1'b0, 1'b1, 32'hD1, 1'b0, 32'h0),   dc_exp(1'b0, 1'b1, 32'h8000_0040, 1'b1, 32'hD1, 1'b0));
    add(wr_in(1'b1, 1'b0, 1'b0, 32'hD2, 1'b0, 32'h0),   dc_exp(1'b0, 1'b1, 32'h8000_0040, 1'b0, 32'hD2, 1'b0));
    add(wr_in(1'b1, 1'b0, 1'b1, 32'hD2, 1'b0, 32'h0),   dc_exp(1'b0, 1'b1, 32'h8000_0040, 1'b1, 32'hD2, 1'b0));
    add(wr_in(1'b1, 1'b0, 1'b0, 32'hD3, 1'b0, 32'h0),   dc_exp(1'b0, 1'b1, 32'h8000_0040, 1'b0, 32'hD3, 1'b0));
    add(wr_in(1'b1, 1'b0, 1'b1, 32'hD3, 1'b0, 32'h0),   dc_exp(1'b0, 1'b1, 32'h8000_0040, 1'b1, 32'hD3, 1'b0));
    add(wr_in(1'b1, 1'b0, 1'b0, 32'hD3, 1'b0, 32'h0),   dc_exp(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,  1'b1));
    add(wr_in(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0),   dc_exp(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,  1'b0));

    step();
    step();
    sys_rst_i = 1'b0;
    @(negedge clk);
    cmp_all("reset state", '0);
    step();

    for (int r = 0; r < vecs.size(); r++) begin
      apply(vecs[r].i);
      @(negedge clk);
      cmp_all($sformatf("table row %0d", r), vecs[r].e);
      step();
    end

    // round-robin: from reset dc wins the first tie, then grants alternate
    apply('0);
    sys_rst_i = 1'b1;
    step();
    sys_rst_i = 1'b0;
    @(negedge clk);
    cmp_all("reset idle", '0);
    ic_req_i  = 1'b1;
    ic_addr_i = 32'h0000_0100;
    dc_req_i  = 1'b1;
    dc_we_i   = 1'b0;
    dc_addr_i = 32'h0000_0204;
    step();
    do_read_burst("rr first dc", 1'b1, 32'h0000_0200, 32'h10, 1'b0);
    step();
    do_read_burst("rr then ic", 1'b0, 32'h0000_0100, 32'h20, 1'b0);
    ic_req_i = 1'b1;
    dc_req_i = 1'b1;
    step();
    do_read_burst("rr tie dc", 1'b1, 32'h0000_0200, 32'h30, 1'b0);
    step();
    do_read_burst("rr tie ic", 1'b0, 32'h0000_0100, 32'h40, 1'b0);

    // command stall: ack withheld for 10 cycles
    ic_addr_i = 32'h0000_5554;
    ic_req_i  = 1'b1;
    step();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("stall cmd %0d", k), {31'd0, mem_cmd_o}, 32'd1);
      chk($sformatf("stall addr %0d", k), mem_addr_o, 32'h0000_5550);
      chk($sformatf("stall strobes %0d", k), {30'd0, ic_valid_o, dc_valid_o}, 32'd0);
      step();
    end
    do_read_burst("stall burst", 1'b0, 32'h0000_5550, 32'h50, 1'b0);

    // reset during the second beat of an icache read
    ic_addr_i = 32'h0000_7004;
    ic_req_i  = 1'b1;
    step();
    mem_cmd_ack_i = 1'b1;
    step();
    mem_cmd_ack_i = 1'b0;
    mem_rvalid_i  = 1'b1;
    mem_rdata_i   = 32'h11;
    step();
    mem_rdata_i = 32'h22;
    sys_rst_i   = 1'b1;
    ic_req_i    = 1'b0;
    step();
    sys_rst_i   = 1'b0;
    mem_rdata_i = 32'h33;
    @(negedge clk);
    cmp_all("after mid-burst reset", '0);
    step();
    mem_rdata_i = 32'h44;
    @(negedge clk);
    cmp_all("late beat ignored", '0);
    step();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'd0;
    dc_req_i     = 1'b1;
    dc_we_i      = 1'b0;
    dc_addr_i    = 32'h0000_9008;
    step();
    do_read_burst("post-reset dc", 1'b1, 32'h0000_9000, 32'hC0, 1'b0);

    // icache holds req one cycle past done: a second burst to the same line
    ic_addr_i = 32'h0000_300C;
    ic_req_i  = 1'b1;
    step();
    do_read_burst("rereq first", 1'b0, 32'h0000_3000, 32'hD0, 1'b1);
    step();
    do_read_burst("rereq second", 1'b0, 32'h0000_3000, 32'hE0, 1'b0);
    @(negedge clk);
    cmp_all("rereq idle", '0);
    step();
    @(negedge clk);
    chk("no third burst", {31'd0, mem_cmd_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
